// File: rtl/mem_init_responder.sv
// rtl/mem_init_responder.sv - init-sweep write target, readback verifier and single-port user RAM
module mem_init_responder #(
    parameter int                 DEPTH      = 256,
    parameter int                 AW         = 8,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              initValid,
    input  logic [31:0]       initAddr,
    input  logic              initDonePuls,
    input  logic              verifyReq,
    input  logic              usrWrEn,
    input  logic [AW-1:0]     usrAddr,
    input  logic [DATA_W-1:0] usrWrData,
    output logic [DATA_W-1:0] usrRdData,
    output logic              busy,
    output logic [AW:0]       fillCount,
    output logic              seqErr,
    output logic              rangeErr,
    output logic              verifyDone,
    output logic              verifyPass,
    output logic [AW:0]       errCount,
    output logic [AW-1:0]     firstErrAddr
);

    typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);
    localparam logic [31:0] DEPTH_32 = 32'(DEPTH);

    state_t              state_q, state_d;
    logic [31:0]         exp_addr_q, exp_addr_d;
    logic [AW:0]         fill_count_q, fill_count_d;
    logic                seq_err_q, seq_err_d;
    logic                range_err_q, range_err_d;
    logic [AW:0]         vcnt_q, vcnt_d;
    logic                verify_done_q, verify_done_d;
    logic                verify_pass_q, verify_pass_d;
    logic [AW:0]         err_count_q, err_count_d;
    logic [AW-1:0]       first_err_addr_q, first_err_addr_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   usr_rd_data_q, usr_rd_data_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   vrd_q;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                beat;
    logic                go_verify;
    logic [31:0]         exp_base;
    logic [AW:0]         fill_base;
    logic [AW:0]         cmp_addr;

    always_comb begin
        state_d          = state_q;
        exp_addr_d       = exp_addr_q;
        fill_count_d     = fill_count_q;
        seq_err_d        = seq_err_q;
        range_err_d      = range_err_q;
        vcnt_d           = vcnt_q;
        verify_done_d    = 1'b0;
        verify_pass_d    = verify_pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        mem_we           = 1'b0;
        mem_waddr        = usrAddr;
        mem_wdata        = usrWrData;
        beat             = 1'b0;
        go_verify        = 1'b0;
        exp_base         = exp_addr_q;
        fill_base        = fill_count_q;
        cmp_addr         = vcnt_q - ONE_W;

        case (state_q)
            IDLE, DONE: begin
                if (initValid) begin
                    beat        = 1'b1;
                    exp_base    = '0;
                    fill_base   = '0;
                    seq_err_d   = 1'b0;
                    range_err_d = 1'b0;
                    state_d     = FILL;
                end else if (verifyReq) begin
                    go_verify = 1'b1;
                end else if (usrWrEn) begin
                    mem_we = 1'b1;
                end
            end
            FILL: begin
                beat      = initValid;
                go_verify = initDonePuls;
            end
            VERIFY: begin
                if (initValid) begin
                    seq_err_d = 1'b1;
                end
                // vcnt counts issued reads; the word read last cycle is compared now
                if (vcnt_q != '0 && vrd_q != INIT_VALUE) begin
                    err_count_d = err_count_q + ONE_W;
                    if (err_count_q == '0) begin
                        first_err_addr_d = cmp_addr[AW-1:0];
                    end
                end
                if (vcnt_q == DEPTH_W) begin
                    state_d       = DONE;
                    verify_done_d = 1'b1;
                    verify_pass_d = (err_count_d == '0) && !seq_err_d && !range_err_d;
                end else begin
                    vcnt_d = vcnt_q + ONE_W;
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (initAddr >= DEPTH_32) begin
                range_err_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = initAddr[AW-1:0];
                mem_wdata = INIT_VALUE;
            end
            if (initAddr != exp_base) begin
                seq_err_d = 1'b1;
            end
            exp_addr_d   = exp_base + 32'd1;
            fill_count_d = (fill_base == DEPTH_W) ? fill_base : fill_base + ONE_W;
        end

        if (go_verify) begin
            state_d          = VERIFY;
            vcnt_d           = '0;
            err_count_d      = '0;
            first_err_addr_d = '0;
            verify_pass_d    = 1'b0;
        end

        busy_d        = (state_d == FILL) || (state_d == VERIFY);
        usr_rd_data_d = (state_q == VERIFY) ? usr_rd_data_q : mem_q[usrAddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            exp_addr_q       <= '0;
            fill_count_q     <= '0;
            seq_err_q        <= 1'b0;
            range_err_q      <= 1'b0;
            vcnt_q           <= '0;
            verify_done_q    <= 1'b0;
            verify_pass_q    <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            busy_q           <= 1'b0;
            usr_rd_data_q    <= '0;
        end else begin
            state_q          <= state_d;
            exp_addr_q       <= exp_addr_d;
            fill_count_q     <= fill_count_d;
            seq_err_q        <= seq_err_d;
            range_err_q      <= range_err_d;
            vcnt_q           <= vcnt_d;
            verify_done_q    <= verify_done_d;
            verify_pass_q    <= verify_pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            busy_q           <= busy_d;
            usr_rd_data_q    <= usr_rd_data_d;
        end
    end

    // RAM array and verify read port carry no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        vrd_q <= mem_q[vcnt_q[AW-1:0]];
    end

    assign usrRdData    = usr_rd_data_q;
    assign busy         = busy_q;
    assign fillCount    = fill_count_q;
    assign seqErr       = seq_err_q;
    assign rangeErr     = range_err_q;
    assign verifyDone   = verify_done_q;
    assign verifyPass   = verify_pass_q;
    assign errCount     = err_count_q;
    assign firstErrAddr = first_err_addr_q;

endmodule

// File: tb/tb_mem_init_responder.sv
// tb/tb_mem_init_responder.sv - self-checking bench for mem_init_responder
module tb_mem_init_responder;

    localparam int                DEPTH      = 256;
    localparam int                AW         = 8;
    localparam int                DATA_W     = 32;
    localparam logic [DATA_W-1:0] INIT_VALUE = '0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              initValid = 1'b0;
    logic [31:0]       initAddr = '0;
    logic              initDonePuls = 1'b0;
    logic              verifyReq = 1'b0;
    logic              usrWrEn = 1'b0;
    logic [AW-1:0]     usrAddr = '0;
    logic [DATA_W-1:0] usrWrData = '0;
    logic [DATA_W-1:0] usrRdData;
    logic              busy;
    logic [AW:0]       fillCount;
    logic              seqErr;
    logic              rangeErr;
    logic              verifyDone;
    logic              verifyPass;
    logic [AW:0]       errCount;
    logic [AW-1:0]     firstErrAddr;

    mem_init_responder #(
        .DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W), .INIT_VALUE(INIT_VALUE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .initValid(initValid), .initAddr(initAddr), .initDonePuls(initDonePuls),
        .verifyReq(verifyReq),
        .usrWrEn(usrWrEn), .usrAddr(usrAddr), .usrWrData(usrWrData), .usrRdData(usrRdData),
        .busy(busy), .fillCount(fillCount), .seqErr(seqErr), .rangeErr(rangeErr),
        .verifyDone(verifyDone), .verifyPass(verifyPass), .errCount(errCount),
        .firstErrAddr(firstErrAddr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                m_seq;
    bit                m_range;
    int                m_fill;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".usrRdData"}, usrRdData, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".fillCount"}, fillCount, 0);
        chk({tag, ".seqErr"}, seqErr, 0);
        chk({tag, ".rangeErr"}, rangeErr, 0);
        chk({tag, ".verifyDone"}, verifyDone, 0);
        chk({tag, ".verifyPass"}, verifyPass, 0);
        chk({tag, ".errCount"}, errCount, 0);
        chk({tag, ".firstErrAddr"}, firstErrAddr, 0);
    endtask

    // Sweep issued from IDLE/DONE: beat i is in order iff its address equals i
    task automatic sweep(input int addrs[$], input bit done_on_last);
        m_seq   = 1'b0;
        m_range = 1'b0;
        m_fill  = 0;
        foreach (addrs[i]) begin
            initValid    = 1'b1;
            initAddr     = 32'(addrs[i]);
            initDonePuls = done_on_last && (i == addrs.size() - 1);
            if (addrs[i] != i) m_seq = 1'b1;
            if (addrs[i] >= DEPTH) m_range = 1'b1;
            else model_mem[addrs[i]] = INIT_VALUE;
            if (m_fill < DEPTH) m_fill++;
            step();
        end
        initValid    = 1'b0;
        initDonePuls = 1'b0;
        initAddr     = '0;
    endtask

    // mode 0: initDonePuls, 1: verifyReq, 2: trigger already sampled on the previous edge
    task automatic run_verify(input string tag, input int mode, input int inject_at);
        int cyc;
        int exp_err;
        int exp_first;
        bit found;
        exp_err   = 0;
        exp_first = 0;
        found     = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            if (model_mem[a] !== INIT_VALUE) begin
                exp_err++;
                if (!found) begin
                    exp_first = a;
                    found     = 1'b1;
                end
            end
        end
        if (mode != 2) begin
            if (mode == 1) verifyReq = 1'b1;
            else initDonePuls = 1'b1;
            step();
            verifyReq    = 1'b0;
            initDonePuls = 1'b0;
        end
        cyc = 1;
        chk({tag, ".busy_in_verify"}, busy, 1);
        while (!verifyDone && cyc < DEPTH + 20) begin
            initValid = (cyc == inject_at);
            initAddr  = 32'($urandom_range(0, DEPTH - 1));
            if (initValid) m_seq = 1'b1;
            step();
            initValid = 1'b0;
            cyc++;
        end
        chk({tag, ".done_latency"}, cyc, DEPTH + 2);
        chk({tag, ".errCount"}, errCount, exp_err);
        chk({tag, ".firstErrAddr"}, firstErrAddr, exp_first);
        chk({tag, ".verifyPass"}, verifyPass, (exp_err == 0) && !m_seq && !m_range);
        chk({tag, ".busy_at_done"}, busy, 0);
        step();
        chk({tag, ".done_one_cycle"}, verifyDone, 0);
        chk({tag, ".pass_held"}, verifyPass, (exp_err == 0) && !m_seq && !m_range);
    endtask

    task automatic uwrite(input string tag, input int addr, input logic [DATA_W-1:0] data);
        usrWrEn   = 1'b1;
        usrAddr   = AW'(addr);
        usrWrData = data;
        step();
        usrWrEn   = 1'b0;
        step();
        model_mem[addr] = data;
        chk({tag, ".usrRdData_c2"}, usrRdData, data);
    endtask

    initial begin
        int q[$];
        int ra;
        int tmp;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Reset asserted asynchronously partway through a sweep
        q = {};
        for (int i = 0; i < 100; i++) q.push_back(i);
        sweep(q, 1'b0);
        chk("partial.fillCount", fillCount, 100);
        chk("partial.busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst_n = 1'b1;
        step();

        // Clean sweep then separate done pulse
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        sweep(q, 1'b0);
        chk("clean.fillCount", fillCount, DEPTH);
        chk("clean.seqErr", seqErr, 0);
        chk("clean.rangeErr", rangeErr, 0);
        chk("clean.busy_fill", busy, 1);
        run_verify("clean", 0, -1);

        // Single corruption, then additional random corruptions
        uwrite("corrupt", 'h2A, 32'h5);
        run_verify("corrupt", 1, -1);
        for (int k = 0; k < 2; k++) begin
            ra = int'($urandom_range(0, DEPTH - 1));
            uwrite("rand_wr", ra, $urandom() | 32'h1);
        end
        for (int k = 0; k < 4; k++) begin
            ra = int'($urandom_range(0, DEPTH - 1));
            usrAddr = AW'(ra);
            step();
            chk("rand_rd", usrRdData, model_mem[ra]);
        end
        run_verify("multi_corrupt", 1, -1);

        // Out-of-order sweep (10 and 11 swapped)
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        tmp = q[10]; q[10] = q[11]; q[11] = tmp;
        sweep(q, 1'b0);
        chk("ooo.seqErr", seqErr, 1);
        chk("ooo.fillCount", fillCount, DEPTH);
        run_verify("ooo", 0, -1);
        chk("ooo.seqErr_sticky", seqErr, 1);

        // Last beat coincides with done pulse; word 255 must still be rewritten
        uwrite("pre255", DEPTH - 1, $urandom() | 32'h1);
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        sweep(q, 1'b1);
        chk("same_cycle.fillCount", fillCount, DEPTH);
        run_verify("same_cycle", 2, -1);

        // initValid while verifying
        run_verify("valid_in_verify", 1, 50);
        chk("valid_in_verify.seqErr", seqErr, 1);

        // Out-of-range beat must not alias onto address 0
        uwrite("pre0", 0, $urandom() | 32'h1);
        q = {};
        q.push_back(DEPTH);
        sweep(q, 1'b0);
        chk("range.rangeErr", rangeErr, 1);
        chk("range.fillCount", fillCount, 1);
        run_verify("range", 0, -1);
        usrAddr = '0;
        step();
        chk("range.addr0_kept", usrRdData, model_mem[0]);

        // Recovery sweep
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        sweep(q, 1'b0);
        chk("recover.rangeErr", rangeErr, 0);
        run_verify("recover", 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_init_responder.md
# mem_init_responder

Memory-side responder for the initialisation sweep stream. It accepts the `initValid`/`initAddr`/`initDonePuls` stream from the memory initialiser and writes `INIT_VALUE` into a local synchronous RAM. It checks that addresses arrive in order and in range, then reads back every word to verify the fill. After verification it serves as a plain single-port RAM with a user write/read port and an on-demand re-verify request.

## Interface
- `DEPTH`, 256 — number of RAM words; power of two.
- `AW`, 8 — RAM address width, log2(DEPTH).
- `DATA_W`, 32 — RAM word width.
- `INIT_VALUE`, 0 — value written for every init beat and expected on verify.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `initValid`  in  1  init write strobe, one beat per cycle.
- `initAddr`  in  32  init word address.
- `initDonePuls`  in  1  one-cycle end-of-sweep pulse.
- `verifyReq`  in  1  one-cycle request to re-run readback verification.
- `usrWrEn`  in  1  user write strobe.
- `usrAddr`  in  AW  user read/write address.
- `usrWrData`  in  DATA_W  user write data.
- `usrRdData`  out  DATA_W  registered read data for `usrAddr`, 1-cycle latency.
- `busy`  out  1  high in FILL or VERIFY.
- `fillCount`  out  AW+1  init beats accepted in the current sweep.
- `seqErr`  out  1  sticky: an init address was out of order.
- `rangeErr`  out  1  sticky: an init address was ≥ DEPTH.
- `verifyDone`  out  1  one-cycle pulse at the end of verification.
- `verifyPass`  out  1  result of the last verification.
- `errCount`  out  AW+1  mismatching words found in the last verification.
- `firstErrAddr`  out  AW  lowest mismatching address in the last verification.

## Operation
- Reset: state IDLE. All outputs are 0, including `usrRdData`. The expected-address counter is 0. RAM contents are not reset.
- States: IDLE, FILL, VERIFY, DONE.
- IDLE/DONE, `initValid`=1:
  - Clear `fillCount`, `seqErr` and `rangeErr`.
  - Set the expected address to 0.
  - Process the beat, then go to FILL.
- Beat processing (IDLE/DONE start beat and FILL):
  - If `initAddr` ≥ DEPTH: set `rangeErr` and drop the write.
  - Otherwise write `INIT_VALUE` at `initAddr[AW-1:0]`.
  - If `initAddr` ≠ expected: set `seqErr`.
  - In all cases increment expected and `fillCount`. `fillCount` saturates at DEPTH.
- FILL, `initDonePuls`=1: go to VERIFY. If `initValid` is high in the same cycle, that beat is processed first.
- `initDonePuls` outside FILL is ignored.
- VERIFY:
  - Read addresses 0..DEPTH-1, one per cycle.
  - Compare each returned word against `INIT_VALUE` on the following cycle.
  - On a mismatch, increment `errCount`. On the first mismatch, latch `firstErrAddr`.
  - After the last compare: pulse `verifyDone`, set `verifyPass` = (`errCount`==0 and not `seqErr` and not `rangeErr`), go to DONE.
- Verify start (entry to VERIFY): clear `errCount`, `firstErrAddr` and `verifyPass`.
- DONE/IDLE, `verifyReq`=1: go to VERIFY. If `initValid` and `verifyReq` are both high, `initValid` wins.
- `usrWrEn` is honoured only in IDLE and DONE; it is ignored while `busy`.
- `usrRdData` reads `usrAddr` in every state except VERIFY. During VERIFY it holds its last value.
- `initValid` during VERIFY: beat ignored, `seqErr` set.
- Asynchronous reset mid-FILL or mid-VERIFY: immediate return to IDLE with reset outputs. The partial RAM contents remain.

## Timing
- Init write: the RAM word is updated at the clock edge where `initValid`=1. `fillCount` and the error flags update at the same edge.
- `busy` rises the cycle after the first accepted init beat.
- Trigger at edge T (`initDonePuls` or `verifyReq` sampled): VERIFY entered at T+1.
- Read of address k is issued in cycle T+1+k; its compare happens in cycle T+2+k.
- `verifyDone` is high for exactly one cycle, at T+DEPTH+2.
- `verifyPass` and `errCount` are valid from T+DEPTH+2 and held until the next verify start.
- `busy` falls at T+DEPTH+2.
- A user write in cycle C is visible on `usrRdData` at C+2 when `usrAddr` is held.

## Test plan
- Clean sweep, DEPTH=256: `initValid` with addr 0..255 on consecutive cycles, then `initDonePuls` → `fillCount`=256, `seqErr`=0, `rangeErr`=0; `verifyDone` 258 cycles after the pulse; `verifyPass`=1, `errCount`=0.
- Corruption: after the clean sweep, `usrWrEn` with addr 0x2A, data 0x5 → `verifyReq` → `verifyPass`=0, `errCount`=1, `firstErrAddr`=0x2A; `usrRdData`=0x5 when read.
- Out of order: sweep 0..255 with addresses 10 and 11 swapped → `seqErr`=1 and sticky; `verifyPass`=0; `errCount`=0.
- Range: one beat with `initAddr`=0x100 → `rangeErr`=1, no RAM write, `verifyPass`=0.
- Same-cycle events: last beat (addr 255) in the same cycle as `initDonePuls` → word 255 written, `verifyPass`=1. `initValid` during VERIFY → `seqErr`=1.
- Reset mid-FILL at beat 100: `rst_n` low → all outputs 0 and state IDLE. A new full sweep afterwards → `verifyPass`=1.
